// File: rtl/audio_rec_play_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : audio_rec_play_ctrl_if
// Description : Single-port sample RAM bus between the record/playback
//               sequencer (master) and the external RAM (slave).
// Signals     : mem_addr  - RAM address (master -> slave)
//               mem_we    - write enable, one-cycle pulse (master -> slave)
//               mem_wdata - write data (master -> slave)
//               mem_rdata - read data, valid one cycle after the address
//                           (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface audio_rec_play_ctrl_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_we,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/audio_rec_play_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : audio_rec_play_ctrl
// Description : Records microphone samples into a single-port sample RAM at
//               the audio sample rate and plays them back on command. Owns
//               the sample-tick divider, RAM address/write enable and the
//               recorded-length register.
// Ports       : clk          - system clock, rising edge
//               rst_n        - asynchronous active-low reset
//               i_btn_rec    - record key (rising edge = command)
//               i_btn_play   - play key (rising edge = command)
//               i_btn_stop   - stop key (rising edge = command)
//               i_mic_in     - current microphone sample
//               mem          - sample RAM bus (master modport)
//               o_audio_out  - playback sample, held between captures
//               o_busy       - high while recording or playing
//               o_done       - one-cycle pulse when REC or PLAY ends
//               o_ledr       - [0]=REC [1]=PLAY [2]=buffer full
//                              [17:3]=top 15 bits of the RAM address
// Options     : LOOP_PLAY_EN - when defined, playback wraps to address 0
//                              after the last recorded sample and runs
//                              until a stop command.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_rec_play_ctrl #(
  parameter int CLK_HZ      = 50000000,
  parameter int SAMPLE_RATE = 48000,
  parameter int DEPTH       = 96000,
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_btn_rec,
  input  wire logic              i_btn_play,
  input  wire logic              i_btn_stop,
  input  wire logic [DATA_W-1:0] i_mic_in,
  audio_rec_play_ctrl_if.master  mem,
  output logic      [DATA_W-1:0] o_audio_out,
  output logic                   o_busy,
  output logic                   o_done,
  output logic      [17:0]       o_ledr
);

  localparam int c_DIV   = CLK_HZ / SAMPLE_RATE;
  localparam int c_CNT_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  // One extra bit so a length equal to a power-of-two DEPTH is representable.
  localparam int c_LEN_W = ADDR_W + 1;

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_DIV - 1);
  localparam logic [c_LEN_W-1:0] c_DEPTH    = c_LEN_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REC  = 2'd1,
    S_PLAY = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_armed;
  logic                r_rec_q;
  logic                r_play_q;
  logic                r_stop_q;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_LEN_W-1:0]  r_idx;
  logic [c_LEN_W-1:0]  r_len;
  logic                r_pend;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_we;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_audio;
  logic                r_done;

  logic                w_rec_edge;
  logic                w_play_edge;
  logic                w_stop_edge;
  logic                w_tick;
  logic [c_LEN_W-1:0]  w_idx_nxt;
  logic [14:0]         w_led_addr;

  // The edge detector is armed one cycle after reset so a key that is held
  // through reset only loads its level and never reads as a fresh press.
  assign w_rec_edge  = r_armed & i_btn_rec  & ~r_rec_q;
  assign w_play_edge = r_armed & i_btn_play & ~r_play_q;
  assign w_stop_edge = r_armed & i_btn_stop & ~r_stop_q;

  assign w_tick    = (r_state != S_IDLE) && (r_cnt == c_CNT_LAST);
  assign w_idx_nxt = r_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_armed     <= 1'b0;
      r_rec_q     <= 1'b0;
      r_play_q    <= 1'b0;
      r_stop_q    <= 1'b0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_pend      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_audio     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_armed  <= 1'b1;
      r_rec_q  <= i_btn_rec;
      r_play_q <= i_btn_play;
      r_stop_q <= i_btn_stop;
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= w_tick ? '0 : r_cnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          // Holding the counter at zero here doubles as the clear on entry.
          r_cnt  <= '0;
          r_pend <= 1'b0;
          if (!w_stop_edge) begin
            if (w_rec_edge) begin
              r_state <= S_REC;
              r_idx   <= '0;
              r_audio <= '0;
            end else if (w_play_edge && (r_len != '0)) begin
              r_state <= S_PLAY;
              r_idx   <= '0;
            end
          end
        end

        S_REC: begin
          if (w_stop_edge) begin
            r_len   <= r_idx;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_tick) begin
            r_mem_we    <= 1'b1;
            r_mem_wdata <= i_mic_in;
            r_mem_addr  <= r_idx[ADDR_W-1:0];
            r_idx       <= w_idx_nxt;
            if (w_idx_nxt == c_DEPTH) begin
              r_len   <= c_DEPTH;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end

        S_PLAY: begin
          if (w_stop_edge) begin
            // Any read in flight is dropped; audio_out keeps its value.
            r_pend  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            // Capture is handled before the tick so that, at a divider of
            // one, a new read launched this cycle is not cancelled.
            if (r_pend) begin
              r_pend  <= 1'b0;
              r_audio <= mem.mem_rdata;
              if (w_idx_nxt == r_len) begin
`ifdef LOOP_PLAY_EN
                r_idx <= '0;
`else
                r_done  <= 1'b1;
                r_state <= S_IDLE;
`endif
              end else begin
                r_idx <= w_idx_nxt;
              end
            end
            if (w_tick) begin
              r_mem_addr <= r_idx[ADDR_W-1:0];
              r_pend     <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Narrow address buses are left-aligned onto the LED field.
  if (ADDR_W >= 15) begin : g_led_addr_slice
    assign w_led_addr = r_mem_addr[ADDR_W-1 -: 15];
  end else begin : g_led_addr_pad
    assign w_led_addr = {r_mem_addr, {(15 - ADDR_W){1'b0}}};
  end

  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_wdata = r_mem_wdata;

  assign o_audio_out = r_audio;
  assign o_done      = r_done;
  assign o_busy      = (r_state != S_IDLE);
  assign o_ledr      = {w_led_addr, (r_len == c_DEPTH),
                        (r_state == S_PLAY), (r_state == S_REC)};

endmodule
`default_nettype wire

// File: tb/tb_audio_rec_play_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_rec_play_ctrl
// Description : Self-checking bench for audio_rec_play_ctrl. A behavioural
//               model tracks time-in-state, sample index and recorded length
//               and predicts every output each cycle; directed scenarios pin
//               the model with literal values, then random key activity runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_rec_play_ctrl;

  localparam int CLK_HZ      = 1000;
  localparam int SAMPLE_RATE = 100;
  localparam int DEPTH       = 8;
  localparam int ADDR_W      = 17;
  localparam int DATA_W      = 16;
  localparam int DIV         = CLK_HZ / SAMPLE_RATE;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic              btn_rec  = 1'b0;
  logic              btn_play = 1'b0;
  logic              btn_stop = 1'b0;
  logic [DATA_W-1:0] mic_in   = '0;
  logic [DATA_W-1:0] audio_out;
  logic              busy;
  logic              done;
  logic [17:0]       ledr;

  audio_rec_play_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  audio_rec_play_ctrl #(
    .CLK_HZ(CLK_HZ), .SAMPLE_RATE(SAMPLE_RATE), .DEPTH(DEPTH),
    .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_btn_rec(btn_rec), .i_btn_play(btn_play), .i_btn_stop(btn_stop),
    .i_mic_in(mic_in), .mem(mem_if),
    .o_audio_out(audio_out), .o_busy(busy), .o_done(done), .o_ledr(ledr)
  );

  always #5 clk = ~clk;

  // External RAM: combinational read, so data for an address driven in one
  // cycle is sampled by the DUT at the following edge.
  logic [DATA_W-1:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = 16'hBEEF;
  always @(posedge clk)
    if (mem_if.mem_we && mem_if.mem_addr < ADDR_W'(DEPTH))
      ram[mem_if.mem_addr[2:0]] <= mem_if.mem_wdata;
  assign mem_if.mem_rdata = (mem_if.mem_addr < ADDR_W'(DEPTH)) ?
                            ram[mem_if.mem_addr[2:0]] : 16'hDEAD;

  // ---------------- checking helpers ----------------
  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 recording, 2 playing. m_el = cycles spent in the mode,
  // a sample tick closes every DIV-th cycle; a playback read launched on a
  // tick is captured at the next edge (m_due).
  int                m_mode, m_el, m_idx, m_len, m_due;
  bit                m_armed, m_prec, m_pplay, m_pstop;
  bit                m_re, m_pe, m_se, m_tick;
  logic [DATA_W-1:0] m_buf [DEPTH];
  logic [ADDR_W-1:0] e_addr;
  logic              e_we, e_done;
  logic [DATA_W-1:0] e_wdata, e_audio;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_el = 0; m_idx = 0; m_len = 0; m_due = -1;
      m_armed = 0; m_prec = 0; m_pplay = 0; m_pstop = 0;
      e_addr = '0; e_we = 0; e_done = 0; e_wdata = '0; e_audio = '0;
    end else begin
      m_re = m_armed && btn_rec  && !m_prec;
      m_pe = m_armed && btn_play && !m_pplay;
      m_se = m_armed && btn_stop && !m_pstop;
      m_armed = 1; m_prec = btn_rec; m_pplay = btn_play; m_pstop = btn_stop;
      e_we = 0; e_done = 0;
      m_tick = (m_mode != 0) && ((m_el % DIV) == DIV - 1);
      case (m_mode)
        0: if (!m_se) begin
             if (m_re) begin
               m_mode = 1; m_idx = 0; m_el = 0; e_audio = '0;
             end else if (m_pe && m_len > 0) begin
               m_mode = 2; m_idx = 0; m_el = 0; m_due = -1;
             end
           end
        1: if (m_se) begin
             m_len = m_idx; e_done = 1; m_mode = 0;
           end else begin
             if (m_tick) begin
               e_we = 1; e_wdata = mic_in; e_addr = ADDR_W'(m_idx);
               m_buf[m_idx] = mic_in;
               m_idx++;
               if (m_idx == DEPTH) begin
                 m_len = DEPTH; e_done = 1; m_mode = 0;
               end
             end
             m_el++;
           end
        default: if (m_se) begin
             e_done = 1; m_mode = 0;
           end else begin
             if (m_el == m_due) begin
               e_audio = m_buf[m_idx];
               m_idx++;
               if (m_idx == m_len) begin
`ifdef LOOP_PLAY_EN
                 m_idx = 0;
`else
                 e_done = 1; m_mode = 0;
`endif
               end
             end
             if (m_tick) begin
               e_addr = ADDR_W'(m_idx); m_due = m_el + 1;
             end
             m_el++;
           end
      endcase
    end
  end

  // ---------------- per-cycle compare + event monitor ----------------
  int                cyc = 0;
  int                n_done = 0;
  int                addr_chg_cyc = 0;
  logic [DATA_W-1:0] prev_audio = '0;
  logic [ADDR_W-1:0] prev_addr  = '0;
  int                q_wr_addr[$], q_wr_data[$], q_wr_cyc[$];
  int                q_aud[$], q_lat[$];
  logic [17:0]       e_ledr;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (chk_en) begin
      e_ledr = {e_addr[ADDR_W-1 -: 15], (m_len == DEPTH), (m_mode == 2), (m_mode == 1)};
      chk("mem_addr",  32'(mem_if.mem_addr),  32'(e_addr));
      chk("mem_we",    32'(mem_if.mem_we),    32'(e_we));
      if (e_we) chk("mem_wdata", 32'(mem_if.mem_wdata), 32'(e_wdata));
      chk("audio_out", 32'(audio_out), 32'(e_audio));
      chk("busy",      32'(busy),      32'(m_mode != 0));
      chk("done",      32'(done),      32'(e_done));
      chk("ledr",      32'(ledr),      32'(e_ledr));
    end
    if (mem_if.mem_we) begin
      q_wr_addr.push_back(int'(mem_if.mem_addr));
      q_wr_data.push_back(int'(mem_if.mem_wdata));
      q_wr_cyc.push_back(cyc);
    end
    if (audio_out != prev_audio) begin
      q_aud.push_back(int'(audio_out));
      q_lat.push_back(cyc - addr_chg_cyc);
    end
    if (mem_if.mem_addr != prev_addr) addr_chg_cyc = cyc;
    if (done) n_done++;
    prev_audio = audio_out;
    prev_addr  = mem_if.mem_addr;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_events();
    q_wr_addr.delete(); q_wr_data.delete(); q_wr_cyc.delete();
    q_aud.delete(); q_lat.delete();
    n_done = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    step(3);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_audio", 32'(audio_out), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_ledr",  32'(ledr), 0);
    chk("rst_addr",  32'(mem_if.mem_addr), 0);
    chk("rst_we",    32'(mem_if.mem_we), 0);
    step(3);

    // Play with nothing recorded is ignored.
    clear_events();
    btn_play = 1; step(3); btn_play = 0; step(30);
    chk("empty_play_busy", 32'(busy), 0);
    chk("empty_play_done", 32'(n_done), 0);

    // Rec and stop in the same cycle: stop wins.
    btn_rec = 1; btn_stop = 1; step(2);
    chk("rec_stop_busy", 32'(busy), 0);
    btn_rec = 0; btn_stop = 0; step(3);
    chk("rec_stop_done", 32'(n_done), 0);

    // Rec and play together start a recording; record to full.
    clear_events();
    btn_rec = 1; btn_play = 1; mic_in = 16'h0FFF;
    for (int n = 0; n < DEPTH; n++) begin
      step(DIV);
      if (n == 0) begin btn_rec = 0; btn_play = 0; end
      mic_in = 16'h1000 + 16'(n);
    end
    step(5);
    chk("full_writes", 32'(q_wr_addr.size()), 8);
    for (int i = 0; i < q_wr_addr.size() && i < DEPTH; i++) begin
      chk("full_wr_addr", 32'(q_wr_addr[i]), 32'(i));
      chk("full_wr_data", 32'(q_wr_data[i]), 32'(16'h1000 + i));
      if (i > 0) chk("full_wr_spacing", 32'(q_wr_cyc[i] - q_wr_cyc[i-1]), 10);
    end
    chk("full_done", 32'(n_done), 1);
    chk("full_led", 32'(ledr[2]), 1);

    // Play the full buffer back.
    clear_events();
    btn_play = 1; step(2); btn_play = 0; step(DIV * DEPTH + 10);
`ifdef LOOP_PLAY_EN
    chk("play_count", 32'(q_aud.size() >= 8), 1);
    chk("play_loop_nodone", 32'(n_done), 0);
    btn_stop = 1; step(3); btn_stop = 0;
`else
    chk("play_count", 32'(q_aud.size()), 8);
`endif
    for (int i = 0; i < q_aud.size() && i < DEPTH; i++) begin
      chk("play_data", 32'(q_aud[i]), 32'(16'h1000 + i));
      chk("play_latency", 32'(q_lat[i]), 1);
    end
    chk("play_done", 32'(n_done), 1);
    chk("play_busy", 32'(busy), 0);

    // Stop a recording after three writes.
    clear_events();
    btn_rec = 1; mic_in = 16'h1FFF;
    for (int n = 0; n < 3; n++) begin
      step(DIV);
      if (n == 0) btn_rec = 0;
      mic_in = 16'h2000 + 16'(n);
    end
    step(5);
    btn_stop = 1; step(2); btn_stop = 0; step(3);
    chk("stop_rec_writes", 32'(q_wr_addr.size()), 3);
    chk("stop_rec_done", 32'(n_done), 1);
    chk("stop_rec_led", 32'(ledr[2]), 0);
    chk("stop_rec_busy", 32'(busy), 0);

    clear_events();
    btn_play = 1; step(2); btn_play = 0; step(60);
`ifdef LOOP_PLAY_EN
    chk("short_play_count", 32'(q_aud.size() >= 6), 1);
    chk("short_play_nodone", 32'(n_done), 0);
    for (int i = 0; i < q_aud.size() && i < 6; i++)
      chk("short_play_data", 32'(q_aud[i]), 32'(16'h2000 + (i % 3)));
    btn_stop = 1; step(3); btn_stop = 0;
`else
    chk("short_play_count", 32'(q_aud.size()), 3);
    for (int i = 0; i < q_aud.size() && i < 3; i++)
      chk("short_play_data", 32'(q_aud[i]), 32'(16'h2000 + i));
`endif
    chk("short_play_done", 32'(n_done), 1);

    // Asynchronous reset in the middle of playback, keys held high.
    btn_play = 1; step(2); btn_play = 0; step(14);
    chk("mid_play_busy", 32'(busy), 1);
    btn_play = 1; btn_rec = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy",  32'(busy), 0);
    chk("async_audio", 32'(audio_out), 0);
    chk("async_addr",  32'(mem_if.mem_addr), 0);
    chk("async_ledr",  32'(ledr), 0);
    chk("async_done",  32'(done), 0);
    step(3);
    #2 rst_n = 1'b1;
    clear_events();
    step(40);
    chk("held_key_busy", 32'(busy), 0);
    chk("held_key_writes", 32'(q_wr_addr.size()), 0);
    chk("held_key_audio", 32'(q_aud.size()), 0);
    btn_play = 0; btn_rec = 0; step(3);

    // Random key activity against the model.
    for (int c = 0; c < 3000; c++) begin
      step(1);
      mic_in = 16'($urandom);
      if ($urandom_range(0, 59) == 0)  btn_rec  = ~btn_rec;
      if ($urandom_range(0, 39) == 0)  btn_play = ~btn_play;
      if ($urandom_range(0, 199) == 0) btn_stop = ~btn_stop;
    end
    btn_rec = 0; btn_play = 0; btn_stop = 0;
    step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
